// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared integer-pipeline definitions.
// Holds the opcode encodings (OPT_*), the opcode/word/ROB-tag types, their
// zero constants, TRUE/FALSE, and the result-FIFO entry record.
package alu_exec_unit_pkg;

    typedef logic [4:0]  INST_OPT_TP;
    typedef logic [31:0] WORD_TP;
    typedef logic [3:0]  ROB_IDX_TP;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam WORD_TP    ZERO_WORD    = 32'd0;
    localparam ROB_IDX_TP ZERO_ROB_IDX = 4'd0;

    localparam INST_OPT_TP OPT_NONE  = 5'd0;
    localparam INST_OPT_TP OPT_LUI   = 5'd1;
    localparam INST_OPT_TP OPT_ADD   = 5'd2;
    localparam INST_OPT_TP OPT_SUB   = 5'd3;
    localparam INST_OPT_TP OPT_XOR   = 5'd4;
    localparam INST_OPT_TP OPT_OR    = 5'd5;
    localparam INST_OPT_TP OPT_AND   = 5'd6;
    localparam INST_OPT_TP OPT_SLT   = 5'd7;
    localparam INST_OPT_TP OPT_SLTU  = 5'd8;
    localparam INST_OPT_TP OPT_SLL   = 5'd9;
    localparam INST_OPT_TP OPT_SRL   = 5'd10;
    localparam INST_OPT_TP OPT_SRA   = 5'd11;
    localparam INST_OPT_TP OPT_ADDI  = 5'd12;
    localparam INST_OPT_TP OPT_XORI  = 5'd13;
    localparam INST_OPT_TP OPT_ORI   = 5'd14;
    localparam INST_OPT_TP OPT_ANDI  = 5'd15;
    localparam INST_OPT_TP OPT_SLTI  = 5'd16;
    localparam INST_OPT_TP OPT_SLTIU = 5'd17;
    localparam INST_OPT_TP OPT_SLLI  = 5'd18;
    localparam INST_OPT_TP OPT_SRLI  = 5'd19;
    localparam INST_OPT_TP OPT_SRAI  = 5'd20;
    localparam INST_OPT_TP OPT_BEQ   = 5'd21;
    localparam INST_OPT_TP OPT_BNE   = 5'd22;
    localparam INST_OPT_TP OPT_BLT   = 5'd23;
    localparam INST_OPT_TP OPT_BGE   = 5'd24;
    localparam INST_OPT_TP OPT_BLTU  = 5'd25;
    localparam INST_OPT_TP OPT_BGEU  = 5'd26;

    typedef struct packed {
        ROB_IDX_TP rob_idx;
        WORD_TP    val;
    } fifo_ent_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: RS->ALU issue bus plus the ALU CDB broadcast port.
//   master: reservation station / CDB arbiter side
//   slave : ALU execution unit side
// Handshakes:
//   issue: the RS may pulse alu_ena in any cycle in which alu_stall was low
//          at the preceding edge; there is no per-op acknowledge.
//   cdb  : cdb_alu_valid/src/val stay stable until the edge where
//          cdb_alu_valid & cdb_gnt are both high; that edge consumes the entry.
interface alu_exec_unit_if;
    import alu_exec_unit_pkg::*;

    logic       alu_ena;
    INST_OPT_TP alu_opt;
    WORD_TP     alu_val1;
    WORD_TP     alu_val2;
    WORD_TP     alu_imm;
    ROB_IDX_TP  alu_rob_idx;
    logic       alu_stall;
    logic       cdb_gnt;
    logic       cdb_alu_valid;
    ROB_IDX_TP  cdb_alu_src;
    WORD_TP     cdb_alu_val;

    modport master (
        output alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx, cdb_gnt,
        input  alu_stall, cdb_alu_valid, cdb_alu_src, cdb_alu_val
    );

    modport slave (
        input  alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx, cdb_gnt,
        output alu_stall, cdb_alu_valid, cdb_alu_src, cdb_alu_val
    );

endinterface

// File: rtl/alu_exec_unit_alu_core.sv
// alu_core: purely combinational RV32I integer evaluator.
// Ports: opt (opcode), val1/val2/imm (operands) -> result (32-bit).
// Branches return 1 when taken, 0 otherwise; unknown opcodes return 0.
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  INST_OPT_TP opt,
    input  WORD_TP     val1,
    input  WORD_TP     val2,
    input  WORD_TP     imm,
    output WORD_TP     result
);

    WORD_TP     op2;
    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    // I-type ops take the immediate as second operand; everything else
    // (R-type and branches) uses val2.
    always_comb begin
        op2 = val2;
        if (opt inside {OPT_ADDI, OPT_XORI, OPT_ORI, OPT_ANDI, OPT_SLTI,
                        OPT_SLTIU, OPT_SLLI, OPT_SRLI, OPT_SRAI}) begin
            op2 = imm;
        end
        shamt = op2[4:0];
        lt_s  = $signed(val1) < $signed(op2);
        lt_u  = val1 < op2;
        eq    = val1 == op2;
    end

    always_comb begin
        result = ZERO_WORD;
        case (opt)
            OPT_LUI:             result = imm;
            OPT_ADD,  OPT_ADDI:  result = val1 + op2;
            OPT_SUB:             result = val1 - op2;
            OPT_XOR,  OPT_XORI:  result = val1 ^ op2;
            OPT_OR,   OPT_ORI:   result = val1 | op2;
            OPT_AND,  OPT_ANDI:  result = val1 & op2;
            OPT_SLT,  OPT_SLTI:  result = {31'd0, lt_s};
            OPT_SLTU, OPT_SLTIU: result = {31'd0, lt_u};
            OPT_SLL,  OPT_SLLI:  result = val1 << shamt;
            OPT_SRL,  OPT_SRLI:  result = val1 >> shamt;
            OPT_SRA,  OPT_SRAI:  result = WORD_TP'($signed(val1) >>> shamt);
            OPT_BEQ:             result = {31'd0, eq};
            OPT_BNE:             result = {31'd0, ~eq};
            OPT_BLT:             result = {31'd0, lt_s};
            OPT_BGE:             result = {31'd0, ~lt_s};
            OPT_BLTU:            result = {31'd0, lt_u};
            OPT_BGEU:            result = {31'd0, ~lt_u};
            default:             result = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execution unit between the ALU reservation station and
// the common data bus. Each accepted op is evaluated in its issue cycle and
// its {rob_idx, result} is queued in an in-order FIFO whose head is offered
// on the CDB until granted.
// Ports:
//   clk, rst  clock; synchronous active-high reset
//   rdy       global ready; low freezes all state
//   rb        ROB rollback; flushes the FIFO and drops the same-cycle op
//   bus       alu_exec_unit_if.slave (issue inputs, alu_stall, cdb_* outputs)
//   perf_ops, perf_stall  (only with ALU_PERF_EN defined) pushed-op count and
//             count of ready cycles spent stalled; cleared by rst only
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_BIT   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rb,
    alu_exec_unit_if.slave bus
`ifdef ALU_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [FIFO_BIT-1:0] PTR_ONE    = FIFO_BIT'(1);
    localparam logic [FIFO_BIT:0]   CNT_ONE    = (FIFO_BIT+1)'(1);
    localparam logic [FIFO_BIT:0]   CNT_FULL   = (FIFO_BIT+1)'(FIFO_DEPTH);
    localparam logic [FIFO_BIT:0]   CNT_ALMOST = (FIFO_BIT+1)'(FIFO_DEPTH - 1);

    fifo_ent_t           mem_q [FIFO_DEPTH];
    fifo_ent_t           mem_d [FIFO_DEPTH];
    logic [FIFO_BIT-1:0] head_q, head_d;
    logic [FIFO_BIT-1:0] tail_q, tail_d;
    logic [FIFO_BIT:0]   count_q, count_d;
    logic                stall_q, stall_d;

    WORD_TP alu_result;
    logic   head_valid;
    logic   push;
    logic   pop;

    alu_core u_alu_core (
        .opt    (bus.alu_opt),
        .val1   (bus.alu_val1),
        .val2   (bus.alu_val2),
        .imm    (bus.alu_imm),
        .result (alu_result)
    );

    assign head_valid = count_q != '0;

    // A push while full is a protocol error and is simply dropped.
    // Pop needs valid already high, so a fresh push never bypasses the FIFO.
    assign push = rdy & ~rb & bus.alu_ena & (bus.alu_opt != OPT_NONE) &
                  (bus.alu_rob_idx != ZERO_ROB_IDX) & (count_q != CNT_FULL);
    assign pop  = rdy & ~rb & head_valid & bus.cdb_gnt;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;
        if (rst || (rdy && rb)) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            stall_d = FALSE;
        end else if (rdy) begin
            if (push) begin
                mem_d[tail_q] = '{rob_idx: bus.alu_rob_idx, val: alu_result};
                tail_d        = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // Asserting at DEPTH-1 keeps one slot free for the op the RS may
            // still issue in the cycle the stall first becomes visible.
            stall_d = count_d >= CNT_ALMOST;
        end
    end

    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        stall_q <= stall_d;
    end

    // Outputs read as zero while the FIFO is empty.
    assign bus.alu_stall     = stall_q;
    assign bus.cdb_alu_valid = head_valid;
    assign bus.cdb_alu_src   = head_valid ? mem_q[head_q].rob_idx : ZERO_ROB_IDX;
    assign bus.cdb_alu_val   = head_valid ? mem_q[head_q].val     : ZERO_WORD;

`ifdef ALU_PERF_EN
    logic [31:0] perf_ops_q,   perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Rollback does not touch these; they wrap naturally at 2^32.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (rst) begin
            perf_ops_d   = '0;
            perf_stall_d = '0;
        end else begin
            if (push) begin
                perf_ops_d = perf_ops_q + 32'd1;
            end
            if (rdy && stall_q) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        perf_ops_q   <= perf_ops_d;
        perf_stall_q <= perf_stall_d;
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
